riscv_mem_wb_buf: RTL and testbench
===================================

# riscv_mem_wb_buf

MEM→WB boundary block of the asynchronous pipeline. It accepts the MEM stage's per-instruction results under a valid/ready handshake and selects the register write-back value from ALU result, load data, PC+4 or immediate. It holds up to two instructions in a 2-entry elastic (skid) buffer and drives the register-file write port and the hazard/forwarding view of both held entries. It lets the MEM stage keep issuing while the WB consumer stalls for one cycle, without a combinational ready path back into MEM.

## Interface
- XLEN, 32 (codebase `XLEN`), data width.
- i_clk  in  1  single clock, rising edge.
- i_rstn  in  1  reset; **one clock; reset is synchronous and active-low**.
- i_MEM_valid  in  1  MEM presents an instruction this cycle.
- o_MEM_ready  out  1  buffer can accept; registered, depends only on state.
- i_MEM_reg_wr_en  in  1  instruction writes rd.
- i_MEM_src_rd  in  2  write-back source: 00 ALU, 01 load data, 10 PC+4, 11 immediate.
- i_MEM_rd  in  5  destination register.
- i_MEM_alu_out, i_MEM_mem_rd_data, i_MEM_pc4, i_MEM_imm  in  XLEN each  candidate sources (load data already extended).
- o_WB_valid  out  1  head entry valid.
- i_WB_ready  in  1  WB consumer accepts head this cycle.
- o_WB_rd_wr_en  out  1  commit strobe to register file.
- o_WB_rd  out  5  head destination.
- o_WB_rd_data  out  XLEN  head write data.
- o_WB_skid_valid  out  1  second entry valid (hazard view).
- o_WB_skid_rd  out  5  second entry destination.
- o_WB_skid_data  out  XLEN  second entry write data.
- o_WB_skid_wr_en  out  1  second entry will write (reg_wr_en and rd≠0).

## Operation
- Source select happens at push; each entry stores only {wr_en, rd[4:0], data[XLEN-1:0]}. Stored wr_en = i_MEM_reg_wr_en & (i_MEM_rd ≠ 0).
- push = i_MEM_valid & o_MEM_ready; pop = o_WB_valid & i_WB_ready.
- States: EMPTY, ONE (head valid), FULL (head + skid valid). Strict FIFO order.
  - EMPTY: push → head ← input, ONE. No push → stay.
  - ONE: push & pop → head ← input, stay ONE. Push only → skid ← input, FULL. Pop only → EMPTY. Neither → stay.
  - FULL: push impossible (ready low). Pop → head ← skid, ONE. No pop → hold.
- o_MEM_ready = (state ≠ FULL) & i_rstn.
- o_WB_valid = state ≠ EMPTY. o_WB_skid_valid = state == FULL.
- o_WB_rd_wr_en = pop & head.wr_en. Register file writes only on a handshake. rd = x0 never commits.
- Hazard unit priority: head is older than skid. Forwarding consumers use skid data when skid_rd matches, else head.
- i_MEM_valid low or ignored inputs: entry contents are don't-care while invalid, but they are held stable, not toggled.

## Timing
- Synchronous reset (i_rstn sampled low on a rising edge): state → EMPTY. All entry fields → 0. All outputs read 0, including o_MEM_ready during the reset cycle. First push is possible on the first edge with i_rstn high.
- Reset mid-operation discards both entries. No commit strobe is generated in the reset cycle even if i_WB_ready = 1.
- Latency: push at edge N → o_WB_valid and o_WB_rd_data valid after edge N; earliest commit in cycle N+1.
- Throughput: 1 instruction/cycle while i_WB_ready stays high. The buffer never exceeds ONE in that case.
- One-cycle WB stall: the entry in flight parks in skid, and ready drops the next cycle. No data is lost because ready is registered.
- Outputs are held stable while o_WB_valid & ~i_WB_ready.
- No combinational path from i_WB_ready to o_MEM_ready. A combinational path exists only from i_WB_ready to o_WB_rd_wr_en.

## Test plan
- Reset: hold i_rstn=0 for 3 cycles with i_MEM_valid=1 → o_MEM_ready=0, o_WB_valid=0, o_WB_rd_wr_en=0. Release → o_MEM_ready=1 next cycle.
- Source select: push four instructions with rd=5, alu=0x11, mem=0x22, pc4=0x33, imm=0x44 and src_rd 00/01/10/11, i_WB_ready=1 → commits on rd 5 with data 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
- Stall/skid: stream A (rd=1, 0xA), B (rd=2, 0xB), C (rd=3, 0xC) with i_WB_ready=0 in the B cycle → state FULL, ready=0, skid shows rd=2/0xB. C is held off, and the commits occur in order A, B, C with no loss or duplication.
- x0 suppression: push rd=0, reg_wr_en=1, data 0xDEAD → o_WB_valid=1 and handshake completes, but o_WB_rd_wr_en stays 0.
- Simultaneous push & pop in ONE: head rd=4 popped while rd=6/0x66 pushed → next cycle the head is rd=6/0x66, state ONE, skid_valid=0.
- Reset while FULL: fill two entries, assert i_rstn=0 for one edge with i_WB_ready=1 → no commit strobe; state EMPTY; both valids 0 afterwards.

Source files
------------

// File: rtl/riscv_mem_wb_buf_if.sv
// MEM->WB boundary bundle: MEM-side push handshake, WB-side commit port and skid hazard view.
// The slave modport is the buffer; the master modport is the MEM producer / WB consumer side.
interface riscv_mem_wb_buf_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_MEM_valid;
  logic            o_MEM_ready;
  logic            i_MEM_reg_wr_en;
  logic [1:0]      i_MEM_src_rd;
  logic [4:0]      i_MEM_rd;
  logic [XLEN-1:0] i_MEM_alu_out;
  logic [XLEN-1:0] i_MEM_mem_rd_data;
  logic [XLEN-1:0] i_MEM_pc4;
  logic [XLEN-1:0] i_MEM_imm;

  logic            o_WB_valid;
  logic            i_WB_ready;
  logic            o_WB_rd_wr_en;
  logic [4:0]      o_WB_rd;
  logic [XLEN-1:0] o_WB_rd_data;
  logic            o_WB_skid_valid;
  logic [4:0]      o_WB_skid_rd;
  logic [XLEN-1:0] o_WB_skid_data;
  logic            o_WB_skid_wr_en;

  modport slave (
    input  i_MEM_valid, i_MEM_reg_wr_en, i_MEM_src_rd, i_MEM_rd,
    input  i_MEM_alu_out, i_MEM_mem_rd_data, i_MEM_pc4, i_MEM_imm,
    input  i_WB_ready,
    output o_MEM_ready,
    output o_WB_valid, o_WB_rd_wr_en, o_WB_rd, o_WB_rd_data,
    output o_WB_skid_valid, o_WB_skid_rd, o_WB_skid_data, o_WB_skid_wr_en
  );

  modport master (
    output i_MEM_valid, i_MEM_reg_wr_en, i_MEM_src_rd, i_MEM_rd,
    output i_MEM_alu_out, i_MEM_mem_rd_data, i_MEM_pc4, i_MEM_imm,
    output i_WB_ready,
    input  o_MEM_ready,
    input  o_WB_valid, o_WB_rd_wr_en, o_WB_rd, o_WB_rd_data,
    input  o_WB_skid_valid, o_WB_skid_rd, o_WB_skid_data, o_WB_skid_wr_en
  );
endinterface

// File: rtl/riscv_mem_wb_buf.sv
// MEM->WB 2-entry skid buffer: selects the write-back value at push and holds head + skid entries.
// MEM ready depends only on registered state, so WB stalls never reach MEM combinationally.
module riscv_mem_wb_buf #(
  parameter int unsigned XLEN = 32
) (
  input logic               i_clk,
  input logic               i_rstn,
  riscv_mem_wb_buf_if.slave bus
);

  typedef struct packed {
    logic            wr_en;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  logic mem_ready;
  logic wb_valid;
  logic skid_valid;
  logic push;
  logic pop;

  always_comb begin
    in_entry       = '0;
    in_entry.wr_en = bus.i_MEM_reg_wr_en & (bus.i_MEM_rd != 5'd0);
    in_entry.rd    = bus.i_MEM_rd;
    unique case (bus.i_MEM_src_rd)
      2'b00:   in_entry.data = bus.i_MEM_alu_out;
      2'b01:   in_entry.data = bus.i_MEM_mem_rd_data;
      2'b10:   in_entry.data = bus.i_MEM_pc4;
      default: in_entry.data = bus.i_MEM_imm;
    endcase
  end

  // Gating with i_rstn keeps every output at zero during the reset cycle.
  assign mem_ready  = i_rstn & (state_q != StFull);
  assign wb_valid   = i_rstn & (state_q != StEmpty);
  assign skid_valid = i_rstn & (state_q == StFull);
  assign push       = bus.i_MEM_valid & mem_ready;
  assign pop        = wb_valid & bus.i_WB_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          head_d  = in_entry;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          skid_d  = in_entry;
          state_d = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.o_MEM_ready     = mem_ready;
  assign bus.o_WB_valid      = wb_valid;
  assign bus.o_WB_rd_wr_en   = pop & head_q.wr_en;
  assign bus.o_WB_rd         = i_rstn ? head_q.rd : 5'd0;
  assign bus.o_WB_rd_data    = i_rstn ? head_q.data : '0;
  assign bus.o_WB_skid_valid = skid_valid;
  assign bus.o_WB_skid_rd    = i_rstn ? skid_q.rd : 5'd0;
  assign bus.o_WB_skid_data  = i_rstn ? skid_q.data : '0;
  assign bus.o_WB_skid_wr_en = skid_valid & skid_q.wr_en;

endmodule

// File: tb/tb_riscv_mem_wb_buf.sv
// Bench for riscv_mem_wb_buf: directed vector table, reset corner sequences and a randomized
// run checked against a queue-based model of the two-entry FIFO.
module tb_riscv_mem_wb_buf;

  localparam int unsigned XLEN = 32;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  riscv_mem_wb_buf_if #(.XLEN(XLEN)) bus ();

  riscv_mem_wb_buf #(.XLEN(XLEN)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic        we;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic        wbr;
    logic        e_valid;
    logic        e_ready;
    logic        e_commit;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_skv;
    logic [4:0]  e_skrd;
    logic [31:0] e_skdata;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t vecs[$];
  ent_t model_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic mv, input logic we, input logic [1:0] src,
                               input logic [4:0] rd, input logic [31:0] alu,
                               input logic [31:0] mem, input logic [31:0] pc4,
                               input logic [31:0] imm, input logic wbr, input logic ev,
                               input logic er, input logic ec, input logic [4:0] erd,
                               input logic [31:0] ed, input logic esv, input logic [4:0] esrd,
                               input logic [31:0] esd);
    vec_t v;
    v.mv = mv; v.we = we; v.src = src; v.rd = rd;
    v.alu = alu; v.mem = mem; v.pc4 = pc4; v.imm = imm; v.wbr = wbr;
    v.e_valid = ev; v.e_ready = er; v.e_commit = ec; v.e_rd = erd; v.e_data = ed;
    v.e_skv = esv; v.e_skrd = esrd; v.e_skdata = esd;
    return v;
  endfunction

  task automatic drive(input logic mv, input logic we, input logic [1:0] src,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4, input logic [31:0] imm, input logic wbr);
    bus.i_MEM_valid       = mv;
    bus.i_MEM_reg_wr_en   = we;
    bus.i_MEM_src_rd      = src;
    bus.i_MEM_rd          = rd;
    bus.i_MEM_alu_out     = alu;
    bus.i_MEM_mem_rd_data = mem;
    bus.i_MEM_pc4         = pc4;
    bus.i_MEM_imm         = imm;
    bus.i_WB_ready        = wbr;
  endtask

  // Inputs change just after the falling edge; outputs are checked #1 later.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_check_and_step(input logic [31:0] srcs[4]);
    int   n;
    logic pop;
    logic push;
    ent_t e;
    n = model_q.size();
    if (!rstn) begin
      chk("rnd_rst_ready", {31'd0, bus.o_MEM_ready}, 32'd0);
      chk("rnd_rst_valid", {31'd0, bus.o_WB_valid}, 32'd0);
      chk("rnd_rst_commit", {31'd0, bus.o_WB_rd_wr_en}, 32'd0);
      model_q.delete();
      return;
    end
    chk("rnd_valid", {31'd0, bus.o_WB_valid}, {31'd0, n > 0});
    chk("rnd_ready", {31'd0, bus.o_MEM_ready}, {31'd0, n < 2});
    chk("rnd_skid_valid", {31'd0, bus.o_WB_skid_valid}, {31'd0, n == 2});
    if (n > 0) begin
      chk("rnd_rd", {27'd0, bus.o_WB_rd}, {27'd0, model_q[0].rd});
      chk("rnd_data", bus.o_WB_rd_data, model_q[0].data);
      chk("rnd_commit", {31'd0, bus.o_WB_rd_wr_en},
          {31'd0, bus.i_WB_ready & model_q[0].wr});
    end else begin
      chk("rnd_commit_empty", {31'd0, bus.o_WB_rd_wr_en}, 32'd0);
    end
    if (n == 2) begin
      chk("rnd_skid_rd", {27'd0, bus.o_WB_skid_rd}, {27'd0, model_q[1].rd});
      chk("rnd_skid_data", bus.o_WB_skid_data, model_q[1].data);
      chk("rnd_skid_wr", {31'd0, bus.o_WB_skid_wr_en}, {31'd0, model_q[1].wr});
    end
    pop  = (n > 0) && bus.i_WB_ready;
    push = bus.i_MEM_valid && (n < 2);
    if (pop) void'(model_q.pop_front());
    if (push) begin
      e.wr   = bus.i_MEM_reg_wr_en && (bus.i_MEM_rd != 5'd0);
      e.rd   = bus.i_MEM_rd;
      e.data = srcs[bus.i_MEM_src_rd];
      model_q.push_back(e);
    end
  endtask

  initial begin
    logic [31:0] srcs[4];
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 5'd7, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1);
    @(negedge clk);

    // Reset held three cycles with MEM valid asserted.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("reset_ready", {31'd0, bus.o_MEM_ready}, 32'd0);
      chk("reset_valid", {31'd0, bus.o_WB_valid}, 32'd0);
      chk("reset_commit", {31'd0, bus.o_WB_rd_wr_en}, 32'd0);
      next_cycle();
    end
    rstn = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    #1;
    chk("release_ready", {31'd0, bus.o_MEM_ready}, 32'd1);
    chk("release_valid", {31'd0, bus.o_WB_valid}, 32'd0);
    next_cycle();

    // Source select: back-to-back pushes with WB always ready.
    vecs.push_back(mkv(1,1,2'b00,5,32'h11,32'h22,32'h33,32'h44,1, 0,1,0,0,0,        0,0,0));
    vecs.push_back(mkv(1,1,2'b01,5,32'h11,32'h22,32'h33,32'h44,1, 1,1,1,5,32'h11,   0,0,0));
    vecs.push_back(mkv(1,1,2'b10,5,32'h11,32'h22,32'h33,32'h44,1, 1,1,1,5,32'h22,   0,0,0));
    vecs.push_back(mkv(1,1,2'b11,5,32'h11,32'h22,32'h33,32'h44,1, 1,1,1,5,32'h33,   0,0,0));
    vecs.push_back(mkv(0,0,2'b00,0,32'h0, 32'h0, 32'h0, 32'h0, 1, 1,1,1,5,32'h44,   0,0,0));
    vecs.push_back(mkv(0,0,2'b00,0,32'h0, 32'h0, 32'h0, 32'h0, 1, 0,1,0,0,0,        0,0,0));
    // Stall/skid: A, B with WB stalled in B's cycle, C held off while FULL.
    vecs.push_back(mkv(1,1,2'b00,1,32'hA, 32'h0, 32'h0, 32'h0, 1, 0,1,0,0,0,        0,0,0));
    vecs.push_back(mkv(1,1,2'b00,2,32'hB, 32'h0, 32'h0, 32'h0, 0, 1,1,0,1,32'hA,    0,0,0));
    vecs.push_back(mkv(1,1,2'b00,3,32'hC, 32'h0, 32'h0, 32'h0, 1, 1,0,1,1,32'hA,    1,2,32'hB));
    vecs.push_back(mkv(1,1,2'b00,3,32'hC, 32'h0, 32'h0, 32'h0, 1, 1,1,1,2,32'hB,    0,0,0));
    vecs.push_back(mkv(0,0,2'b00,0,32'h0, 32'h0, 32'h0, 32'h0, 1, 1,1,1,3,32'hC,    0,0,0));
    // x0 destination never commits.
    vecs.push_back(mkv(1,1,2'b00,0,32'hDEAD,32'h0,32'h0,32'h0, 1, 0,1,0,0,0,        0,0,0));
    vecs.push_back(mkv(0,0,2'b00,0,32'h0, 32'h0, 32'h0, 32'h0, 1, 1,1,0,0,32'hDEAD, 0,0,0));
    // Simultaneous push and pop while ONE.
    vecs.push_back(mkv(1,1,2'b00,4,32'h44,32'h0, 32'h0, 32'h0, 0, 0,1,0,0,0,        0,0,0));
    vecs.push_back(mkv(1,1,2'b00,6,32'h66,32'h0, 32'h0, 32'h0, 1, 1,1,1,4,32'h44,   0,0,0));
    vecs.push_back(mkv(0,0,2'b00,0,32'h0, 32'h0, 32'h0, 32'h0, 0, 1,1,0,6,32'h66,   0,0,0));
    vecs.push_back(mkv(0,0,2'b00,0,32'h0, 32'h0, 32'h0, 32'h0, 1, 1,1,1,6,32'h66,   0,0,0));
    vecs.push_back(mkv(0,0,2'b00,0,32'h0, 32'h0, 32'h0, 32'h0, 1, 0,1,0,0,0,        0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].mv, vecs[i].we, vecs[i].src, vecs[i].rd, vecs[i].alu, vecs[i].mem,
            vecs[i].pc4, vecs[i].imm, vecs[i].wbr);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.o_WB_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_ready", i), {31'd0, bus.o_MEM_ready}, {31'd0, vecs[i].e_ready});
      chk($sformatf("vec%0d_commit", i), {31'd0, bus.o_WB_rd_wr_en},
          {31'd0, vecs[i].e_commit});
      chk($sformatf("vec%0d_skv", i), {31'd0, bus.o_WB_skid_valid}, {31'd0, vecs[i].e_skv});
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_rd", i), {27'd0, bus.o_WB_rd}, {27'd0, vecs[i].e_rd});
        chk($sformatf("vec%0d_data", i), bus.o_WB_rd_data, vecs[i].e_data);
      end
      if (vecs[i].e_skv) begin
        chk($sformatf("vec%0d_skrd", i), {27'd0, bus.o_WB_skid_rd}, {27'd0, vecs[i].e_skrd});
        chk($sformatf("vec%0d_skdata", i), bus.o_WB_skid_data, vecs[i].e_skdata);
        chk($sformatf("vec%0d_skwr", i), {31'd0, bus.o_WB_skid_wr_en}, 32'd1);
      end
      next_cycle();
    end

    // Reset while FULL: fill two entries with WB stalled, then reset with WB ready.
    drive(1'b1, 1'b1, 2'b00, 5'd8, 32'h88, 32'h0, 32'h0, 32'h0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 2'b00, 5'd9, 32'h99, 32'h0, 32'h0, 32'h0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    #1;
    chk("full_skid_valid", {31'd0, bus.o_WB_skid_valid}, 32'd1);
    chk("full_ready", {31'd0, bus.o_MEM_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("rstfull_commit", {31'd0, bus.o_WB_rd_wr_en}, 32'd0);
    chk("rstfull_ready", {31'd0, bus.o_MEM_ready}, 32'd0);
    next_cycle();
    rstn = 1'b1;
    #1;
    chk("after_rst_valid", {31'd0, bus.o_WB_valid}, 32'd0);
    chk("after_rst_skid_valid", {31'd0, bus.o_WB_skid_valid}, 32'd0);
    chk("after_rst_ready", {31'd0, bus.o_MEM_ready}, 32'd1);
    chk("after_rst_rd_data", bus.o_WB_rd_data, 32'd0);
    next_cycle();

    // Randomized traffic with occasional resets against the queue model.
    model_q.delete();
    for (int c = 0; c < 600; c++) begin
      srcs[0] = $urandom;
      srcs[1] = $urandom;
      srcs[2] = $urandom;
      srcs[3] = $urandom;
      rstn = ($urandom_range(0, 49) != 0);
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            srcs[0], srcs[1], srcs[2], srcs[3], ($urandom_range(0, 9) < 6));
      #1;
      model_check_and_step(srcs);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
